// File: rtl/dim_stream_parser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parser_pkg
//  Description : Shared constants and sizing helper for the dimension parser.
//  Revision    : 1.0 - initial release
// ============================================================================
package parser_pkg;

    localparam int PROTO_W = 8;

    // Address dims are absolute; port/proto indices count from the first dim
    // after the 2*IP_W/DIM_W address dims.
    localparam int DIM_SRC_IP0  = 0;
    localparam int DIM_SRC_PORT = 0;
    localparam int DIM_DST_PORT = 1;
    localparam int DIM_PROTO    = 2;

    function automatic int calc_num_dims(input int ip_w, input int dim_w, input int proto_en);
        return 2 * (ip_w / dim_w) + 2 + proto_en;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dim_stream_parser_if.sv
`default_nettype none
// ============================================================================
//  Module      : dim_stream_parser_if
//  Description : Packet-in / dimension-vector-out handshake bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dim_stream_parser_if #(
    parameter int DIM_W    = 16,
    parameter int IP_W     = 32,
    parameter int PORT_W   = 16,
    parameter int PROTO_EN = 0
);
    localparam int NUM_DIMS = parser_pkg::calc_num_dims(IP_W, DIM_W, PROTO_EN);

    logic                            packet_valid;
    logic                            packet_ready;
    logic [IP_W-1:0]                 src_ip;
    logic [IP_W-1:0]                 dst_ip;
    logic [PORT_W-1:0]               src_port;
    logic [PORT_W-1:0]               dst_port;
    logic [parser_pkg::PROTO_W-1:0]  proto;
    logic                            dims_valid;
    logic                            dims_ready;
    logic [NUM_DIMS*DIM_W-1:0]       dims_bus;

    modport master (
        output packet_valid, src_ip, dst_ip, src_port, dst_port, proto, dims_ready,
        input  packet_ready, dims_valid, dims_bus
    );

    modport slave (
        input  packet_valid, src_ip, dst_ip, src_port, dst_port, proto, dims_ready,
        output packet_ready, dims_valid, dims_bus
    );

endinterface
`default_nettype wire

// File: rtl/dim_stream_parser_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with occupancy count and show-ahead head.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == C_DEPTH);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign pop_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            // Only the post-reset head is cleared so the output reads zero.
            r_mem[0] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dim_stream_parser.sv
`default_nettype none
// ============================================================================
//  Module      : dim_stream_parser
//  Description : Maps packet header fields to a buffered vector of dimensions.
//  Revision    : 1.0 - initial release
// ============================================================================
module dim_stream_parser
    import parser_pkg::*;
#(
    parameter int DIM_W      = 16,
    parameter int IP_W       = 32,
    parameter int PORT_W     = 16,
    parameter int PROTO_EN   = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    dim_stream_parser_if.slave            bus,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [31:0]                   pkt_count
);
    localparam int IP_DIMS   = IP_W / DIM_W;
    localparam int ADDR_DIMS = 2 * IP_DIMS;
    localparam int NUM_DIMS  = calc_num_dims(IP_W, DIM_W, PROTO_EN);
    localparam int VEC_W     = NUM_DIMS * DIM_W;
    localparam int CORE_W    = (ADDR_DIMS + 2) * DIM_W;

    if (IP_W % DIM_W != 0) begin : g_chk_ip_w
        $error("IP_W must be a multiple of DIM_W");
    end
    if (PORT_W > DIM_W) begin : g_chk_port_w
        $error("PORT_W must not exceed DIM_W");
    end
    if (PROTO_EN != 0 && DIM_W < PROTO_W) begin : g_chk_proto_w
        $error("DIM_W must be at least 8 when PROTO_EN is set");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [CORE_W-1:0] w_core;
    logic [VEC_W-1:0]  w_dims;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [31:0]       r_pkt_count;

    // Address chunks go out most-significant chunk first (lowest dim index).
    always_comb begin
        w_core = '0;
        for (int i = 0; i < IP_DIMS; i++) begin
            w_core[(DIM_SRC_IP0 + i) * DIM_W +: DIM_W] =
                bus.src_ip[(IP_DIMS - 1 - i) * DIM_W +: DIM_W];
            w_core[(DIM_SRC_IP0 + IP_DIMS + i) * DIM_W +: DIM_W] =
                bus.dst_ip[(IP_DIMS - 1 - i) * DIM_W +: DIM_W];
        end
        w_core[(ADDR_DIMS + DIM_SRC_PORT) * DIM_W +: DIM_W] = DIM_W'(bus.src_port);
        w_core[(ADDR_DIMS + DIM_DST_PORT) * DIM_W +: DIM_W] = DIM_W'(bus.dst_port);
    end

    if (PROTO_EN != 0) begin : g_proto
        localparam int PROTO_LSB = (ADDR_DIMS + DIM_PROTO) * DIM_W;
        assign w_dims[CORE_W-1:0]          = w_core;
        assign w_dims[PROTO_LSB +: DIM_W]  = DIM_W'(bus.proto);
    end else begin : g_no_proto
        assign w_dims = w_core;
    end

    // Ready depends only on the registered occupancy, never on dims_ready.
    assign bus.packet_ready = !w_full;
    assign bus.dims_valid   = !w_empty;
    assign w_push           = bus.packet_valid && bus.packet_ready;
    assign w_pop            = bus.dims_valid && bus.dims_ready;

    sync_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_dims),
        .pop       (w_pop),
        .pop_data  (bus.dims_bus),
        .count     (fill_level),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_count <= '0;
        end else if (w_pop) begin
            r_pkt_count <= r_pkt_count + 32'd1;
        end
    end

    assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire
